// File: rtl/ahb_pkg.sv
// Shared AHB-Lite definitions used by the SRAM slave and the master glue.
// Holds transfer encodings, response codes, slave states and lane helpers.
package ahb_pkg;

  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'b00,
    TRANS_BUSY   = 2'b01,
    TRANS_NONSEQ = 2'b10,
    TRANS_SEQ    = 2'b11
  } htrans_t;

  localparam logic [2:0] SIZE_BYTE = 3'b000;
  localparam logic [2:0] SIZE_HALF = 3'b001;
  localparam logic [2:0] SIZE_WORD = 3'b010;

  localparam logic RESP_OKAY  = 1'b0;
  localparam logic RESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_DATA = 2'b01,
    ST_ERR1 = 2'b10,
    ST_ERR2 = 2'b11
  } slv_state_t;

  // Sizes above a word are never aligned, which folds the size check in here.
  function automatic logic size_aligned(input logic [2:0] size, input logic [1:0] addr_lo);
    case (size)
      SIZE_BYTE: return 1'b1;
      SIZE_HALF: return ~addr_lo[0];
      SIZE_WORD: return (addr_lo == 2'b00);
      default:   return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] byte_enables(input logic [2:0] size, input logic [1:0] addr_lo);
    case (size)
      SIZE_BYTE: return 4'b0001 << addr_lo;
      SIZE_HALF: return addr_lo[1] ? 4'b1100 : 4'b0011;
      default:   return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/ahb_be_ram.sv
// Word-wide single-clock RAM with per-byte write enables and a
// combinational read port; contents are never reset.
module ahb_be_ram #(
  parameter int MEM_WORDS = 1024,
  parameter int AW        = $clog2(MEM_WORDS)
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic [3:0]    we,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [MEM_WORDS];

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite slave exposing on-chip SRAM: address capture, legality check,
// programmable data-phase wait states and a two-cycle ERROR response.
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter int MEM_WORDS   = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [3:0]  hprot,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic        hreadyout,
  output logic        hresp,
  output logic [31:0] hr_data
);

  localparam int AW = $clog2(MEM_WORDS);

  slv_state_t    state;
  slv_state_t    next_state;
  logic [AW+1:0] addr_q;
  logic          write_q;
  logic [2:0]    size_q;
  logic [3:0]    wcnt;
  logic          capture;
  logic          accept;
  logic          legal;
  logic          data_done;
  logic [3:0]    we;
  logic [31:0]   rdata;
  logic          unused_ok;

  assign unused_ok = ^{hprot, htrans[0]};

  assign capture   = hsel & hready & htrans[1];
  assign accept    = capture & hreadyout;
  assign legal     = (haddr[31:AW+2] == '0) && size_aligned(hsize, haddr[1:0]);
  assign data_done = (state == ST_DATA) && (wcnt == 4'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE, ST_ERR2: begin
        if (accept) next_state = legal ? ST_DATA : ST_ERR1;
        else        next_state = ST_IDLE;
      end
      ST_DATA: begin
        if (wcnt != 4'd0) next_state = ST_DATA;
        else if (accept)  next_state = legal ? ST_DATA : ST_ERR1;
        else              next_state = ST_IDLE;
      end
      ST_ERR1: next_state = ST_ERR2;
      default: next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    hreadyout = 1'b1;
    hresp     = RESP_OKAY;
    case (state)
      ST_DATA: hreadyout = (wcnt == 4'd0);
      ST_ERR1: begin
        hreadyout = 1'b0;
        hresp     = RESP_ERROR;
      end
      ST_ERR2: hresp = RESP_ERROR;
      default: ;
    endcase
  end

  // Address-phase attributes are held for the whole data phase.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= SIZE_BYTE;
    end else if (accept) begin
      addr_q  <= haddr[AW+1:0];
      write_q <= hwrite;
      size_q  <= hsize;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                 wcnt <= 4'd0;
    else if (accept)                            wcnt <= legal ? 4'(WAIT_STATES) : 4'd0;
    else if (state == ST_DATA && wcnt != 4'd0)  wcnt <= wcnt - 4'd1;
  end

  // Only a completing legal write touches memory; errored slots never reach DATA.
  assign we = (data_done && write_q) ? byte_enables(size_q, addr_q[1:0]) : 4'b0000;

  ahb_be_ram #(
    .MEM_WORDS (MEM_WORDS),
    .AW        (AW)
  ) u_ram (
    .clk   (clk),
    .addr  (addr_q[AW+1:2]),
    .we    (we),
    .wdata (hwdata),
    .rdata (rdata)
  );

  assign hr_data = (state == ST_DATA && !write_q) ? rdata : 32'h0;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Scoreboard bench for ahb_sram_slave: one zero-wait and one 3-wait instance,
// each driven by directed vectors whose per-cycle responses are queued.
module tb_ahb_sram_slave;
  import ahb_pkg::*;

  localparam int MW = 64;

  typedef struct {
    logic        rdy;
    logic        resp;
    logic [31:0] data;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  logic        hsel_a, hwrite_a, hready_a, hreadyout_a, hresp_a;
  logic [31:0] haddr_a, hwdata_a, hr_data_a;
  logic [1:0]  htrans_a;
  logic [2:0]  hsize_a;

  logic        hsel_b, hwrite_b, hready_b, hreadyout_b, hresp_b;
  logic [31:0] haddr_b, hwdata_b, hr_data_b;
  logic [1:0]  htrans_b;
  logic [2:0]  hsize_b;

  // Single-slave bus: the interconnect returns this slave's ready as hready.
  assign hready_a = hreadyout_a;
  assign hready_b = hreadyout_b;

  ahb_sram_slave #(.MEM_WORDS(MW), .WAIT_STATES(0)) dut_a (
    .clk(clk), .reset(rst_n), .hsel(hsel_a), .haddr(haddr_a), .htrans(htrans_a),
    .hwrite(hwrite_a), .hsize(hsize_a), .hprot(4'h3), .hwdata(hwdata_a),
    .hready(hready_a), .hreadyout(hreadyout_a), .hresp(hresp_a), .hr_data(hr_data_a)
  );

  ahb_sram_slave #(.MEM_WORDS(MW), .WAIT_STATES(3)) dut_b (
    .clk(clk), .reset(rst_n), .hsel(hsel_b), .haddr(haddr_b), .htrans(htrans_b),
    .hwrite(hwrite_b), .hsize(hsize_b), .hprot(4'h3), .hwdata(hwdata_b),
    .hready(hready_b), .hreadyout(hreadyout_b), .hresp(hresp_b), .hr_data(hr_data_b)
  );

  exp_t sb_a[$];
  exp_t sb_b[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic checkOutput(input exp_t e, input logic rdy, input logic resp,
                             input logic [31:0] data);
    n_checks++;
    if (rdy !== e.rdy || resp !== e.resp || data !== e.data) begin
      n_fail++;
      $display("[TB] FAIL %s: got hreadyout=%b hresp=%b hr_data=%h, want hreadyout=%b hresp=%b hr_data=%h",
               e.name, rdy, resp, data, e.rdy, e.resp, e.data);
    end
  endtask

  always @(negedge clk) begin : mon_a
    exp_t e;
    if (sb_a.size() > 0) begin
      e = sb_a.pop_front();
      checkOutput(e, hreadyout_a, hresp_a, hr_data_a);
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (sb_b.size() > 0) begin
      e = sb_b.pop_front();
      checkOutput(e, hreadyout_b, hresp_b, hr_data_b);
    end
  end

  // Drive one cycle on bus A (use_b=0) or B (use_b=1) and queue its expected response.
  task automatic applyStimulus(input bit use_b, input logic rst, input logic sel,
                               input logic [1:0] trans, input logic [31:0] addr,
                               input logic wr, input logic [2:0] size, input logic [31:0] wdata,
                               input logic e_rdy, input logic e_resp, input logic [31:0] e_data,
                               input string name);
    exp_t e;
    e.rdy  = e_rdy;
    e.resp = e_resp;
    e.data = e_data;
    e.name = name;
    rst_n  = rst;
    if (!use_b) begin
      hsel_a = sel; htrans_a = trans; haddr_a = addr; hwrite_a = wr; hsize_a = size; hwdata_a = wdata;
      sb_a.push_back(e);
    end else begin
      hsel_b = sel; htrans_b = trans; haddr_b = addr; hwrite_b = wr; hsize_b = size; hwdata_b = wdata;
      sb_b.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit use_b, input logic [31:0] wdata, input logic e_rdy,
                      input logic e_resp, input logic [31:0] e_data, input string name);
    applyStimulus(use_b, 1'b1, 1'b0, TRANS_IDLE, 32'h0, 1'b0, SIZE_WORD, wdata,
                  e_rdy, e_resp, e_data, name);
  endtask

  task automatic xfer(input bit use_b, input logic [31:0] addr, input logic wr,
                      input logic [2:0] size, input logic [31:0] wdata, input logic e_rdy,
                      input logic e_resp, input logic [31:0] e_data, input string name);
    applyStimulus(use_b, 1'b1, 1'b1, TRANS_NONSEQ, addr, wr, size, wdata,
                  e_rdy, e_resp, e_data, name);
  endtask

  initial begin
    hsel_a = 0; htrans_a = TRANS_IDLE; haddr_a = 0; hwrite_a = 0; hsize_a = SIZE_WORD; hwdata_a = 0;
    hsel_b = 0; htrans_b = TRANS_IDLE; haddr_b = 0; hwrite_b = 0; hsize_b = SIZE_WORD; hwdata_b = 0;
    rst_n = 1'b1;
    #2;
    rst_n = 1'b0;
    @(posedge clk);
    #1;

    applyStimulus(0, 1'b0, 0, TRANS_IDLE, 0, 0, SIZE_WORD, 0, 1, 0, 0, "reset_state_a");
    applyStimulus(1, 1'b0, 0, TRANS_IDLE, 0, 0, SIZE_WORD, 0, 1, 0, 0, "reset_state_b");

    // Zero-wait instance: word write then back-to-back read
    idle(0, 0, 1, 0, 0, "a_idle");
    xfer(0, 32'h10, 1, SIZE_WORD, 0,            1, 0, 0,            "wr10_addr");
    xfer(0, 32'h10, 0, SIZE_WORD, 32'hDEADBEEF, 1, 0, 0,            "wr10_data");
    idle(0, 0,                                  1, 0, 32'hDEADBEEF, "raw_same_addr");

    // Byte and halfword lane merges
    xfer(0, 32'h10, 1, SIZE_WORD, 0,            1, 0, 0,            "wr10b_addr");
    xfer(0, 32'h12, 1, SIZE_BYTE, 32'h11223344, 1, 0, 0,            "byte12_addr");
    xfer(0, 32'h10, 0, SIZE_WORD, 32'h00AA0000, 1, 0, 0,            "rd10_addr");
    idle(0, 0,                                  1, 0, 32'h11AA3344, "byte_merge");
    xfer(0, 32'h12, 1, SIZE_HALF, 0,            1, 0, 0,            "half12_addr");
    xfer(0, 32'h10, 0, SIZE_WORD, 32'hCAFE0000, 1, 0, 0,            "rd10c_addr");
    idle(0, 0,                                  1, 0, 32'hCAFE3344, "half_merge");

    // Misaligned word: two-cycle error, no write, read accepted in ERR2
    xfer(0, 32'h00, 1, SIZE_WORD, 0,            1, 0, 0,            "wr00_addr");
    xfer(0, 32'h02, 1, SIZE_WORD, 32'h01020304, 1, 0, 0,            "misaligned_addr");
    idle(0, 32'hFFFFFFFF,                       0, 1, 0,            "misaligned_err1");
    xfer(0, 32'h00, 0, SIZE_WORD, 32'hFFFFFFFF, 1, 1, 0,            "misaligned_err2");
    idle(0, 0,                                  1, 0, 32'h01020304, "read_after_err2");

    // Odd halfword with master cancel, then illegal size
    xfer(0, 32'h11, 0, SIZE_HALF, 0, 1, 0, 0, "odd_half_addr");
    idle(0, 0, 0, 1, 0, "odd_half_err1");
    idle(0, 0, 1, 1, 0, "odd_half_err2");
    idle(0, 0, 1, 0, 0, "cancel_no_capture");
    xfer(0, 32'h10, 0, 3'b011, 0, 1, 0, 0, "size3_addr");
    idle(0, 0, 0, 1, 0, "size3_err1");
    idle(0, 0, 1, 1, 0, "size3_err2");

    // Address range boundaries
    xfer(0, 32'(MW*4 - 4), 1, SIZE_WORD, 0,            1, 0, 0,            "last_wr_addr");
    xfer(0, 32'(MW*4 - 4), 0, SIZE_WORD, 32'h0BADF00D, 1, 0, 0,            "last_rd_addr");
    idle(0, 0,                                         1, 0, 32'h0BADF00D, "last_word");
    xfer(0, 32'(MW*4), 0, SIZE_WORD, 0, 1, 0, 0, "oor_addr");
    idle(0, 0, 0, 1, 0, "oor_err1");
    idle(0, 0, 1, 1, 0, "oor_err2");

    // BUSY and unselected slots are zero-wait OKAY and never write
    applyStimulus(0, 1, 1, TRANS_BUSY,   32'h10, 1, SIZE_WORD, 0,            1, 0, 0, "busy_addr");
    idle(0, 32'h99999999, 1, 0, 0, "busy_no_data");
    applyStimulus(0, 1, 0, TRANS_NONSEQ, 32'h10, 1, SIZE_WORD, 32'h99999999, 1, 0, 0, "unsel_addr");
    idle(0, 32'h99999999, 1, 0, 0, "unsel_no_data");
    xfer(0, 32'h10, 0, SIZE_WORD, 32'h99999999, 1, 0, 0,            "rd10_final_addr");
    idle(0, 0,                                  1, 0, 32'hCAFE3344, "busy_unsel_no_write");

    // Three-wait instance: write, pipelined read, exact wait count
    idle(1, 0, 1, 0, 0, "b_idle");
    xfer(1, 32'h20, 1, SIZE_WORD, 0,            1, 0, 0,            "b_wr_addr");
    idle(1, 32'h55AA55AA,                       0, 0, 0,            "b_wr_wait1");
    idle(1, 32'h55AA55AA,                       0, 0, 0,            "b_wr_wait2");
    idle(1, 32'h55AA55AA,                       0, 0, 0,            "b_wr_wait3");
    xfer(1, 32'h20, 0, SIZE_WORD, 32'h55AA55AA, 1, 0, 0,            "b_wr_done");
    idle(1, 0,                                  0, 0, 32'h55AA55AA, "b_rd_wait1");
    idle(1, 0,                                  0, 0, 32'h55AA55AA, "b_rd_wait2");
    idle(1, 0,                                  0, 0, 32'h55AA55AA, "b_rd_wait3");
    idle(1, 0,                                  1, 0, 32'h55AA55AA, "b_rd_done");
    idle(1, 0,                                  1, 0, 0,            "b_idle2");

    // Reset during the second wait cycle of a write drops the write
    xfer(1, 32'h20, 1, SIZE_WORD, 0, 1, 0, 0, "b_rst_wr_addr");
    idle(1, 32'h12345678, 0, 0, 0, "b_rst_wait1");
    applyStimulus(1, 1'b0, 0, TRANS_IDLE, 0, 0, SIZE_WORD, 32'h12345678, 1, 0, 0, "b_rst_asserted");
    idle(1, 32'h12345678, 1, 0, 0, "b_rst_released");
    xfer(1, 32'h20, 0, SIZE_WORD, 0, 1, 0, 0,            "b_rd2_addr");
    idle(1, 0,                       0, 0, 32'h55AA55AA, "b_rd2_wait1");
    idle(1, 0,                       0, 0, 32'h55AA55AA, "b_rd2_wait2");
    idle(1, 0,                       0, 0, 32'h55AA55AA, "b_rd2_wait3");
    idle(1, 0,                       1, 0, 32'h55AA55AA, "b_rst_write_dropped");

    n_checks++;
    if (sb_a.size() != 0 || sb_b.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL scoreboard_drain: got %0d/%0d pending, want 0/0", sb_a.size(), sb_b.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
